// File: rtl/midi_capture.sv
// MIDI byte-stream capture: turns NoteOn/NoteOff traffic into timed monophonic
// segments and writes them as playback words into the player's MIDI region.
//
// parser state | meaning
// P_STAT       | no usable running status; waiting for a status byte
// P_D1         | expecting first data byte (note number)
// P_D2         | expecting second data byte (velocity)
//
// write state  | meaning
// S_IDLE       | no write in flight
// S_WR_NOTE    | writing segment word to MIDI_BASE + idx
// S_WR_LEN     | writing idx + 1 to the length register
module midi_capture #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int MS_DIV    = CLK_FRE / 1000,
  parameter int MIDI_BASE = 16,
  parameter int MIDI_LEN  = 48,
  parameter int LENT_ADDR = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  input  logic        enable,
  output logic [7:0]  wrAddr,
  output logic [3:0]  wrSize,
  output logic [31:0] wrData,
  output logic [5:0]  eventCount,
  output logic        overflow,
  output logic        busy
);

  localparam logic [1:0] P_STAT    = 2'd0;
  localparam logic [1:0] P_D1      = 2'd1;
  localparam logic [1:0] P_D2      = 2'd2;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR_NOTE = 2'd1;
  localparam logic [1:0] S_WR_LEN  = 2'd2;

  localparam int DIV_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(MS_DIV - 1);
  localparam logic [5:0] IDX_FULL = 6'(MIDI_LEN);

  logic              en_q;
  logic [1:0]        pstate;
  logic [1:0]        wstate;
  logic              rs_note;
  logic              rs_on;
  logic [7:0]        d1;
  logic [7:0]        cur_note;
  logic [7:0]        cur_velo;
  logic [15:0]       elapsed;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        idx;
  logic [31:0]       seg_word;
  logic              fall_pend;
  logic              overflow_q;

  logic       en_rise, en_fall, run, byte_ok, tick;
  logic       midi_ev, note_on, note_off, do_stop, fall_close, do_close;
  logic       emit, drop;
  logic [7:0] mapped;

  function automatic logic [7:0] note_map(input logic [7:0] n);
    case (n)
      8'd48:   note_map = 8'd1;
      8'd50:   note_map = 8'd2;
      8'd52:   note_map = 8'd3;
      8'd53:   note_map = 8'd4;
      8'd55:   note_map = 8'd5;
      8'd57:   note_map = 8'd6;
      8'd59:   note_map = 8'd7;
      8'd60:   note_map = 8'd8;
      8'd62:   note_map = 8'd9;
      8'd64:   note_map = 8'd10;
      8'd65:   note_map = 8'd11;
      8'd67:   note_map = 8'd12;
      8'd69:   note_map = 8'd13;
      8'd71:   note_map = 8'd14;
      default: note_map = 8'd0;
    endcase
  endfunction

  assign en_rise  = enable & ~en_q;
  assign en_fall  = ~enable & en_q;
  assign run      = enable & en_q;
  assign byte_ok  = rxValid & run;
  assign tick     = run && (div_cnt == '0);
  assign mapped   = note_map(d1);

  assign midi_ev  = byte_ok && (pstate == P_D2) && !rxData[7] && rs_note;
  assign note_on  = midi_ev && rs_on && (rxData != 8'd0);
  assign note_off = midi_ev && !note_on;
  assign do_stop  = note_off && (mapped == cur_note);
  // A close requested by the falling edge waits until any in-flight write drains.
  assign fall_close = (en_fall | fall_pend) && (wstate == S_IDLE);
  assign do_close   = note_on | do_stop | fall_close;
  assign emit = do_close && (elapsed != 16'd0) && (idx != IDX_FULL) && (wstate == S_IDLE);
  assign drop = do_close && (elapsed != 16'd0) && (idx == IDX_FULL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) en_q <= 1'b0;
    else       en_q <= enable;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pstate  <= P_STAT;
      rs_note <= 1'b0;
      rs_on   <= 1'b0;
      d1      <= 8'd0;
    end else if (en_rise) begin
      pstate  <= P_STAT;
      rs_note <= 1'b0;
      rs_on   <= 1'b0;
    end else if (byte_ok && rxData < 8'hF8) begin
      if (rxData >= 8'hF0) begin
        pstate  <= P_STAT;
        rs_note <= 1'b0;
        rs_on   <= 1'b0;
      end else if (rxData[7]) begin
        pstate  <= P_D1;
        rs_note <= (rxData[7:5] == 3'b100);
        rs_on   <= rxData[4];
      end else begin
        case (pstate)
          P_STAT: if (rs_note) begin
            d1     <= rxData;
            pstate <= P_D2;
          end
          P_D1: begin
            d1     <= rxData;
            pstate <= P_D2;
          end
          default: pstate <= P_D1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_note <= 8'd0;
      cur_velo <= 8'd0;
      elapsed  <= 16'd0;
      div_cnt  <= DIV_RELOAD;
    end else if (en_rise) begin
      cur_note <= 8'd0;
      cur_velo <= 8'd0;
      elapsed  <= 16'd0;
      div_cnt  <= DIV_RELOAD;
    end else begin
      // A tick landing on a close is discarded; the new segment starts at zero.
      if (do_close) begin
        elapsed <= 16'd0;
        div_cnt <= DIV_RELOAD;
      end else if (run) begin
        if (tick) begin
          div_cnt <= DIV_RELOAD;
          if (elapsed != 16'hFFFF) elapsed <= elapsed + 16'd1;
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
      if (note_on) begin
        cur_note <= mapped;
        cur_velo <= rxData;
      end else if (do_stop) begin
        cur_note <= 8'd0;
        cur_velo <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate     <= S_IDLE;
      seg_word   <= 32'd0;
      idx        <= 6'd0;
      overflow_q <= 1'b0;
      fall_pend  <= 1'b0;
    end else begin
      case (wstate)
        S_IDLE: if (emit) begin
          wstate   <= S_WR_NOTE;
          seg_word <= {cur_note, cur_velo, elapsed};
        end
        S_WR_NOTE: wstate <= S_WR_LEN;
        default:   wstate <= S_IDLE;
      endcase

      if (en_rise)                idx <= 6'd0;
      else if (wstate == S_WR_LEN) idx <= idx + 6'd1;

      if (en_rise)   overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;

      if (en_rise || fall_close) fall_pend <= 1'b0;
      else if (en_fall)          fall_pend <= 1'b1;
    end
  end

  always_comb begin
    wrAddr = 8'd0;
    wrSize = 4'h0;
    wrData = 32'd0;
    case (wstate)
      S_WR_NOTE: begin
        wrAddr = 8'(MIDI_BASE) + {2'b00, idx};
        wrSize = 4'hF;
        wrData = seg_word;
      end
      S_WR_LEN: begin
        wrAddr = 8'(LENT_ADDR);
        wrSize = 4'hF;
        wrData = {26'd0, idx + 6'd1};
      end
      default: ;
    endcase
  end

  assign eventCount = idx;
  assign overflow   = overflow_q;
  assign busy       = (wstate != S_IDLE);

endmodule

// File: tb/tb_midi_capture.sv
// Directed bench for midi_capture with a 1-cycle millisecond tick so segment
// times equal clock counts between the closing edges.
module tb_midi_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        enable;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_size;
  logic [31:0] wr_data;
  logic [5:0]  event_count;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [39:0] wq[$];

  midi_capture #(
    .CLK_FRE(1000), .MS_DIV(1), .MIDI_BASE(16), .MIDI_LEN(48), .LENT_ADDR(5)
  ) dut (
    .clk(clk), .rstn(rst_n), .rxData(rx_data), .rxValid(rx_valid), .enable(enable),
    .wrAddr(wr_addr), .wrSize(wr_size), .wrData(wr_data),
    .eventCount(event_count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && wr_size == 4'hF) wq.push_back({wr_addr, wr_data});

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the byte is taken at the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  // Rising edge of enable lands on the posedge just before return ("p0").
  task automatic arm();
    enable = 1'b0;
    wait_cycles(6);
    wq.delete();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    wait_cycles(3);
    checks++;
    if ({wr_addr, wr_size, wr_data, event_count, overflow, busy} !== 52'd0) begin
      failures++;
      $display("FAIL reset_in got addr=%h size=%h data=%h cnt=%0d ovf=%b busy=%b exp all 0",
               wr_addr, wr_size, wr_data, event_count, overflow, busy);
    end
    rst_n = 1'b1;
    wait_cycles(2);
    checks++;
    if ({wr_addr, wr_size, wr_data, event_count, overflow, busy} !== 52'd0) begin
      failures++;
      $display("FAIL reset_out got addr=%h size=%h data=%h cnt=%0d ovf=%b busy=%b exp all 0",
               wr_addr, wr_size, wr_data, event_count, overflow, busy);
    end
  endtask

  task automatic test_note_basic();
    logic [39:0] exp_q[$];
    arm();
    wait_cycles(2);
    send3(8'h90, 8'h3C, 8'h64);
    checks++;
    if ({wr_size, wr_addr, wr_data, busy} !== {4'hF, 8'd16, 32'h0000_0004, 1'b1}) begin
      failures++;
      $display("FAIL basic_wr_note got size=%h addr=%0d data=%h busy=%b exp F 16 00000004 1",
               wr_size, wr_addr, wr_data, busy);
    end
    @(negedge clk);
    checks++;
    if ({wr_size, wr_addr, wr_data} !== {4'hF, 8'd5, 32'd1}) begin
      failures++;
      $display("FAIL basic_wr_len got size=%h addr=%0d data=%h exp F 5 00000001",
               wr_size, wr_addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({busy, wr_size, event_count} !== {1'b0, 4'h0, 6'd1}) begin
      failures++;
      $display("FAIL basic_idle got busy=%b size=%h cnt=%0d exp 0 0 1", busy, wr_size, event_count);
    end
    wait_cycles(246);
    send3(8'h80, 8'h3C, 8'h00);
    wait_cycles(4);
    exp_q.push_back({8'd16, 32'h0000_0004});
    exp_q.push_back({8'd5,  32'd1});
    exp_q.push_back({8'd17, 32'h0864_00FA});
    exp_q.push_back({8'd5,  32'd2});
    checks++;
    if (wq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_nwrites got=%0d exp=%0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_write%0d got=%h exp=%h", i, wq[i], exp_q[i]);
      end
    end
    checks++;
    if (event_count !== 6'd2) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=2", event_count);
    end
  endtask

  task automatic test_running_status();
    logic [39:0] exp_q[$];
    arm();
    send3(8'h90, 8'h30, 8'h40);
    wait_cycles(4);
    send_byte(8'h34); send_byte(8'h50);
    wait_cycles(6);
    send_byte(8'h34); send_byte(8'h00);
    wait_cycles(4);
    exp_q.push_back({8'd16, 32'h0000_0002});
    exp_q.push_back({8'd5,  32'd1});
    exp_q.push_back({8'd17, 32'h0140_0005});
    exp_q.push_back({8'd5,  32'd2});
    exp_q.push_back({8'd18, 32'h0350_0007});
    exp_q.push_back({8'd5,  32'd3});
    checks++;
    if (wq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rs_nwrites got=%0d exp=%0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rs_write%0d got=%h exp=%h", i, wq[i], exp_q[i]);
      end
    end
    checks++;
    if (event_count !== 6'd3) begin
      failures++;
      $display("FAIL rs_count got=%0d exp=3", event_count);
    end
  endtask

  task automatic test_realtime_filter();
    logic [39:0] exp_q[$];
    arm();
    send3(8'hB0, 8'h07, 8'h7F);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_cc_busy got=%b exp=0", busy);
    end
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'h64);
    wait_cycles(8);
    send3(8'h80, 8'h3C, 8'h00);
    wait_cycles(4);
    exp_q.push_back({8'd16, 32'h0000_0006});
    exp_q.push_back({8'd5,  32'd1});
    exp_q.push_back({8'd17, 32'h0864_000A});
    exp_q.push_back({8'd5,  32'd2});
    checks++;
    if (wq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rt_nwrites got=%0d exp=%0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rt_write%0d got=%h exp=%h", i, wq[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_noise();
    logic [39:0] exp_q[$];
    arm();
    send3(8'h90, 8'h3C, 8'h64);
    wait_cycles(2);
    send3(8'h80, 8'h3E, 8'h40);
    send3(8'h90, 8'h3D, 8'h64);
    wait_cycles(8);
    send3(8'h80, 8'h3D, 8'h00);
    wait_cycles(4);
    exp_q.push_back({8'd16, 32'h0000_0002});
    exp_q.push_back({8'd5,  32'd1});
    exp_q.push_back({8'd17, 32'h0864_0007});
    exp_q.push_back({8'd5,  32'd2});
    exp_q.push_back({8'd18, 32'h0064_000A});
    exp_q.push_back({8'd5,  32'd3});
    checks++;
    if (wq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL noise_nwrites got=%0d exp=%0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL noise_write%0d got=%h exp=%h", i, wq[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fall_close();
    logic [39:0] exp_q[$];
    arm();
    send3(8'h90, 8'h3C, 8'h55);
    wait_cycles(12);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({wr_size, wr_addr, wr_data} !== {4'hF, 8'd17, 32'h0855_000C}) begin
      failures++;
      $display("FAIL fall_wr_note got size=%h addr=%0d data=%h exp F 17 0855000C",
               wr_size, wr_addr, wr_data);
    end
    wait_cycles(4);
    exp_q.push_back({8'd16, 32'h0000_0002});
    exp_q.push_back({8'd5,  32'd1});
    exp_q.push_back({8'd17, 32'h0855_000C});
    exp_q.push_back({8'd5,  32'd2});
    checks++;
    if (wq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL fall_nwrites got=%0d exp=%0d", wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL fall_write%0d got=%h exp=%h", i, wq[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fall_during_write();
    arm();
    send3(8'h90, 8'h3C, 8'h55);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, wr_size} !== {1'b0, 4'h0}) begin
      failures++;
      $display("FAIL fall_busy_idle got busy=%b size=%h exp 0 0", busy, wr_size);
    end
    @(negedge clk);
    checks++;
    if ({wr_size, wr_addr, wr_data} !== {4'hF, 8'd17, 32'h0855_0001}) begin
      failures++;
      $display("FAIL fall_busy_deferred got size=%h addr=%0d data=%h exp F 17 08550001",
               wr_size, wr_addr, wr_data);
    end
    wait_cycles(4);
    checks++;
    if (wq.size() != 4 || event_count !== 6'd2) begin
      failures++;
      $display("FAIL fall_busy_total got writes=%0d cnt=%0d exp 4 2", wq.size(), event_count);
    end
  endtask

  task automatic test_overflow();
    arm();
    for (int i = 0; i < 49; i++) begin
      send3(8'h90, (i % 2 == 0) ? 8'h3C : 8'h3E, 8'h40);
      @(negedge clk);
    end
    wait_cycles(4);
    checks++;
    if (wq.size() != 96) begin
      failures++;
      $display("FAIL ovf_nwrites got=%0d exp=96", wq.size());
    end
    if (wq.size() == 96) begin
      checks++;
      if (wq[95] !== {8'd5, 32'd48} || wq[94][39:32] !== 8'd63) begin
        failures++;
        $display("FAIL ovf_last got len=%h note=%h exp len 0500000030 addr 63", wq[95], wq[94]);
      end
    end
    checks++;
    if ({overflow, event_count} !== {1'b1, 6'd48}) begin
      failures++;
      $display("FAIL ovf_flag got ovf=%b cnt=%0d exp 1 48", overflow, event_count);
    end
    arm();
    checks++;
    if ({overflow, event_count} !== {1'b0, 6'd0}) begin
      failures++;
      $display("FAIL ovf_rearm got ovf=%b cnt=%0d exp 0 0", overflow, event_count);
    end
  endtask

  task automatic test_saturation();
    arm();
    send3(8'h90, 8'h3C, 8'h64);
    wait_cycles(65600);
    send3(8'h80, 8'h3C, 8'h00);
    wait_cycles(4);
    checks++;
    if (wq.size() != 4) begin
      failures++;
      $display("FAIL sat_nwrites got=%0d exp=4", wq.size());
    end else begin
      checks++;
      if (wq[2] !== {8'd17, 32'h0864_FFFF}) begin
        failures++;
        $display("FAIL sat_word got=%h exp=%h", wq[2], {8'd17, 32'h0864_FFFF});
      end
    end
  endtask

  task automatic test_reset_mid_write();
    arm();
    send3(8'h90, 8'h3C, 8'h64);
    checks++;
    if (wr_size !== 4'hF) begin
      failures++;
      $display("FAIL rst_pre_size got=%h exp=F", wr_size);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_size, wr_addr, busy, event_count} !== {4'h0, 8'd0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL rst_async got size=%h addr=%0d busy=%b cnt=%0d exp 0 0 0 0",
               wr_size, wr_addr, busy, event_count);
    end
    @(negedge clk);
    checks++;
    if (wr_size !== 4'h0) begin
      failures++;
      $display("FAIL rst_next_size got=%h exp=0", wr_size);
    end
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  initial begin
    test_reset();
    test_note_basic();
    test_running_status();
    test_realtime_filter();
    test_noise();
    test_fall_close();
    test_fall_during_write();
    test_overflow();
    test_saturation();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
